bpu_pht_ctrl: RTL

Controller for the branch predictor's 2-bit-counter pattern history table (PHT) in the BPU. It owns the global history register (GHR) and forms the PHT lookup index. It queues branch-resolution updates from the backend and drains them, one per cycle, into the PHT's single update port. The drain yields to conflicting same-cycle lookups, and the GHR is restored on mispredict.

---
 rtl/bpu_pkg.sv | 20 ++
 rtl/bpu_upd_fifo.sv | 42 ++++
 rtl/bpu_pht_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared types and the PHT index function for the branch predictor.
package bpu_pkg;

  localparam int BPU_PHT_WIDTH = 6;
  localparam int BPU_PC_WIDTH  = 32;

  typedef struct packed {
    logic [BPU_PHT_WIDTH-1:0] addr;
    logic                     taken;
  } pht_upd_t;

  // Word-aligned PC bits folded with history; bimodal callers pass h = 0.
  function automatic logic [BPU_PHT_WIDTH-1:0] bpu_pht_index(
    input logic [BPU_PC_WIDTH-1:0]  pc,
    input logic [BPU_PHT_WIDTH-1:0] h
  );
    return pc[BPU_PHT_WIDTH+1:2] ^ h;
  endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is combinational, 1-cycle push-to-visible.
// Push is dropped when full, pop when empty; no same-cycle bypass.
module bpu_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Same slot index with different wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/bpu_pht_ctrl.sv
// PHT controller: GHR, lookup index, queued update drain yielding to same-address lookups.
// Lookup is combinational; updates drain 1 cycle after enqueue at earliest. BPU_GSHARE_EN selects gshare over bimodal.
module bpu_pht_ctrl
  import bpu_pkg::*;
#(
  parameter int PHT_WIDTH   = 6,
  parameter int GHR_WIDTH   = 6,
  parameter int PC_WIDTH    = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  output logic [PHT_WIDTH-1:0] pht_lookup_addr,
  input  logic                 pht_pred_taken,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic [GHR_WIDTH-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  output logic                 pht_branch_en,
  output logic [PHT_WIDTH-1:0] pht_update_addr,
  output logic                 pht_taken
);

  logic [PHT_WIDTH-1:0] lookup_hist;
  logic [PHT_WIDTH-1:0] upd_hist;

`ifdef BPU_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr;
  logic                 accept;

  assign accept = upd_valid && upd_ready;

  // Recovery overrides the speculative shift; that cycle's lookup is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (accept && upd_mispredict) begin
      ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken};
    end else if (lookup_valid) begin
      ghr <= {ghr[GHR_WIDTH-2:0], pht_pred_taken};
    end
  end

  assign pred_ghr    = ghr;
  assign lookup_hist = PHT_WIDTH'(ghr);
  assign upd_hist    = PHT_WIDTH'(upd_ghr);
`else
  logic unused_hist;

  assign unused_hist = ^{upd_ghr, upd_mispredict};
  assign pred_ghr    = '0;
  assign lookup_hist = '0;
  assign upd_hist    = '0;
`endif

  assign pht_lookup_addr = bpu_pht_index(lookup_pc, lookup_hist);
  assign pred_taken      = pht_pred_taken;

  pht_upd_t enq;
  pht_upd_t head;
  logic     full;
  logic     empty;
  logic     conflict;
  logic     drain;

  assign enq.addr  = bpu_pht_index(upd_pc, upd_hist);
  assign enq.taken = upd_taken;

  assign upd_ready = !full;
  assign conflict  = lookup_valid && (head.addr == pht_lookup_addr);
  assign drain     = !empty && !conflict;

  bpu_upd_fifo #(
    .WIDTH ($bits(pht_upd_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (upd_valid),
    .data  (enq),
    .pop   (drain),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign pht_branch_en   = drain;
  assign pht_update_addr = head.addr;
  assign pht_taken       = head.taken;

endmodule
